// File: rtl/ibex_ex_unit_seq_if.sv
// Issue, functional-unit and writeback signals of the EX-stage sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface ibex_ex_unit_seq_if #(
    parameter int NumUnits    = 4,
    parameter int ResultWidth = 91,
    parameter int ExcWidth    = 5
);
    localparam int UW = $clog2(NumUnits);

    logic                            issue_valid_i;
    logic                            issue_ready_o;
    logic [UW-1:0]                   issue_unit_i;
    logic                            issue_is_cap_i;
    logic                            kill_i;
    logic [NumUnits-1:0]             unit_start_o;
    logic [NumUnits-1:0]             unit_kill_o;
    logic [NumUnits-1:0]             unit_valid_i;
    logic [NumUnits*ResultWidth-1:0] unit_result_i;
    logic [NumUnits*ExcWidth-1:0]    unit_exc_i;
    logic                            res_valid_o;
    logic                            res_ready_i;
    logic [ResultWidth-1:0]          res_data_o;
    logic [ExcWidth-1:0]             res_exc_o;
    logic                            res_is_cap_o;
    logic [1:0]                      res_err_o;
    logic                            busy_o;

    modport master (
        input  issue_valid_i, issue_unit_i, issue_is_cap_i, kill_i,
               unit_valid_i, unit_result_i, unit_exc_i, res_ready_i,
        output issue_ready_o, unit_start_o, unit_kill_o, res_valid_o,
               res_data_o, res_exc_o, res_is_cap_o, res_err_o, busy_o
    );

    modport slave (
        output issue_valid_i, issue_unit_i, issue_is_cap_i, kill_i,
               unit_valid_i, unit_result_i, unit_exc_i, res_ready_i,
        input  issue_ready_o, unit_start_o, unit_kill_o, res_valid_o,
               res_data_o, res_exc_o, res_is_cap_o, res_err_o, busy_o
    );
endinterface

// File: rtl/ibex_ex_unit_seq.sv
// EX-stage sequencer: dispatches one op at a time to a functional unit, watches for
// hung units and holds the result in a valid/ready writeback register.
module ibex_ex_unit_seq #(
    parameter int NumUnits    = 4,
    parameter int ResultWidth = 91,
    parameter int ExcWidth    = 5,
    parameter int MaxCycles   = 64
) (
    input logic                clk_i,
    input logic                rst_i,
    ibex_ex_unit_seq_if.master bus
);
    localparam int UW = $clog2(NumUnits);
    localparam int NP = 2 ** UW;
    localparam int CW = (MaxCycles > 0) ? $clog2(MaxCycles + 1) : 1;
    localparam logic [CW-1:0] CntLast = (CW)'((MaxCycles > 0) ? MaxCycles - 1 : 0);
    localparam logic [UW:0]   NuLim   = (UW + 1)'(NumUnits);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    state_e                 state_q;
    logic [UW-1:0]          unit_q;
    logic [CW-1:0]          cnt_q;
    logic                   res_valid_q;
    logic [ResultWidth-1:0] res_data_q;
    logic [ExcWidth-1:0]    res_exc_q;
    logic                   res_is_cap_q;
    logic [1:0]             res_err_q;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v == {CW{1'b1}}) ? v : v + 1'b1;
    endfunction

    function automatic logic [NumUnits-1:0] onehot(input logic [UW-1:0] idx);
        logic [NP-1:0] oh;
        oh      = '0;
        oh[idx] = 1'b1;
        return oh[NumUnits-1:0];
    endfunction

    // Unit slices padded to a power of two so any index selects a defined zero value.
    logic [NP-1:0]          valid_pad;
    logic [ResultWidth-1:0] result_arr [NP];
    logic [ExcWidth-1:0]    exc_arr    [NP];

    assign valid_pad = (NP)'(bus.unit_valid_i);

    for (genvar g = 0; g < NP; g++) begin : g_slice
        if (g < NumUnits) begin : g_real
            assign result_arr[g] = bus.unit_result_i[g*ResultWidth +: ResultWidth];
            assign exc_arr[g]    = bus.unit_exc_i[g*ExcWidth +: ExcWidth];
        end else begin : g_pad
            assign result_arr[g] = '0;
            assign exc_arr[g]    = '0;
        end
    end

    logic issue_ready;
    logic accept;
    logic issue_legal;
    logic timeout;

    always_comb begin
        issue_ready = 1'b0;
        unique case (state_q)
            IDLE:    issue_ready = !bus.kill_i;
            RESP:    issue_ready = bus.res_ready_i && !bus.kill_i;
            default: issue_ready = 1'b0;
        endcase
        if (rst_i) issue_ready = 1'b0;
    end

    assign accept      = bus.issue_valid_i && issue_ready;
    assign issue_legal = {1'b0, bus.issue_unit_i} < NuLim;
    assign timeout     = (MaxCycles != 0) && (state_q == WAIT) && (cnt_q == CntLast)
                         && !valid_pad[unit_q];

    assign bus.issue_ready_o = issue_ready;
    assign bus.unit_start_o  = (accept && issue_legal) ? onehot(bus.issue_unit_i) : '0;
    assign bus.unit_kill_o   = (!rst_i && (state_q == WAIT) && (bus.kill_i || timeout))
                               ? onehot(unit_q) : '0;
    assign bus.res_valid_o   = res_valid_q;
    assign bus.res_data_o    = res_data_q;
    assign bus.res_exc_o     = res_exc_q;
    assign bus.res_is_cap_o  = res_is_cap_q;
    assign bus.res_err_o     = res_err_q;
    assign bus.busy_o        = (state_q != IDLE);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            unit_q       <= '0;
            cnt_q        <= '0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_exc_q    <= '0;
            res_is_cap_q <= 1'b0;
            res_err_q    <= 2'b00;
        end else if (bus.kill_i) begin
            state_q     <= IDLE;
            res_valid_q <= 1'b0;
        end else if (accept) begin
            unit_q       <= bus.issue_unit_i;
            res_is_cap_q <= bus.issue_is_cap_i;
            cnt_q        <= '0;
            if (!issue_legal) begin
                state_q     <= RESP;
                res_valid_q <= 1'b1;
                res_data_q  <= '0;
                res_exc_q   <= '0;
                res_err_q   <= 2'b01;
            end else if (valid_pad[bus.issue_unit_i]) begin
                state_q     <= RESP;
                res_valid_q <= 1'b1;
                res_data_q  <= result_arr[bus.issue_unit_i];
                res_exc_q   <= exc_arr[bus.issue_unit_i];
                res_err_q   <= 2'b00;
            end else begin
                state_q     <= WAIT;
                res_valid_q <= 1'b0;
            end
        end else begin
            unique case (state_q)
                WAIT: begin
                    cnt_q <= sat_inc(cnt_q);
                    if (valid_pad[unit_q]) begin
                        state_q     <= RESP;
                        res_valid_q <= 1'b1;
                        res_data_q  <= result_arr[unit_q];
                        res_exc_q   <= exc_arr[unit_q];
                        res_err_q   <= 2'b00;
                    end else if (timeout) begin
                        state_q     <= RESP;
                        res_valid_q <= 1'b1;
                        res_data_q  <= '0;
                        res_exc_q   <= '0;
                        res_err_q   <= 2'b10;
                    end
                end
                RESP: begin
                    if (bus.res_ready_i) begin
                        state_q     <= IDLE;
                        res_valid_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ibex_ex_unit_seq.sv
// Directed and randomized checks of ibex_ex_unit_seq against a transaction-level model
// (six units so that indices 6 and 7 are illegal, watchdog of 8 cycles).
module tb_ibex_ex_unit_seq;
    localparam int NU = 6;
    localparam int RW = 91;
    localparam int EW = 5;
    localparam int MC = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ibex_ex_unit_seq_if #(.NumUnits(NU), .ResultWidth(RW), .ExcWidth(EW)) bus ();

    ibex_ex_unit_seq #(.NumUnits(NU), .ResultWidth(RW), .ExcWidth(EW), .MaxCycles(MC)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    // Functional-unit stimulus, packed onto the bus each cycle.
    logic [NU-1:0] uv;
    logic [RW-1:0] ures [NU];
    logic [EW-1:0] uexc [NU];

    int vectors     = 0;
    int miscompares = 0;
    int starts_seen = 0;
    int kills_seen  = 0;
    int busy_seen   = 0;
    logic [NU-1:0] last_kill;

    // Model: an op is either in flight at a unit, or its result is held for WB, or neither.
    bit            m_inflight, m_have, m_fresh;
    int            m_unit, m_waited;
    logic [RW-1:0] m_data;
    logic [EW-1:0] m_exc;
    logic          m_cap;
    logic [1:0]    m_err;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        bit            ready, acc, tmo;
        int            iu;
        logic [NU-1:0] e_start, e_kill;
        bus.unit_valid_i = uv;
        for (int u = 0; u < NU; u++) begin
            bus.unit_result_i[u*RW +: RW] = ures[u];
            bus.unit_exc_i[u*EW +: EW]    = uexc[u];
        end
        #1;
        iu      = int'(bus.issue_unit_i);
        ready   = !rst && !bus.kill_i && !m_inflight && (!m_have || bus.res_ready_i);
        acc     = bus.issue_valid_i && ready;
        e_start = (acc && iu < NU) ? NU'(1) << iu : '0;
        tmo     = m_inflight && !uv[m_unit] && (m_waited == MC - 1);
        e_kill  = (!rst && m_inflight && (bus.kill_i || tmo)) ? NU'(1) << m_unit : '0;
        chk("issue_ready", 128'(bus.issue_ready_o), 128'(ready));
        chk("unit_start", 128'(bus.unit_start_o), 128'(e_start));
        chk("unit_kill", 128'(bus.unit_kill_o), 128'(e_kill));
        chk("busy", 128'(bus.busy_o), 128'(m_inflight || m_have));
        chk("res_valid", 128'(bus.res_valid_o), 128'(m_have));
        if (m_have || m_fresh) begin
            chk("res_data", 128'(bus.res_data_o), 128'(m_data));
            chk("res_exc", 128'(bus.res_exc_o), 128'(m_exc));
            chk("res_is_cap", 128'(bus.res_is_cap_o), 128'(m_cap));
            chk("res_err", 128'(bus.res_err_o), 128'(m_err));
        end
        starts_seen += $countones(bus.unit_start_o);
        if (bus.unit_kill_o != '0) begin
            kills_seen++;
            last_kill = bus.unit_kill_o;
        end
        if (bus.busy_o) busy_seen++;

        if (rst) begin
            m_inflight = 0; m_have = 0; m_fresh = 1;
            m_data = '0; m_exc = '0; m_cap = 1'b0; m_err = 2'b00;
        end else if (bus.kill_i) begin
            m_inflight = 0; m_have = 0;
        end else if (acc) begin
            m_fresh = 0; m_unit = iu; m_cap = bus.issue_is_cap_i; m_waited = 0;
            if (iu >= NU) begin
                m_have = 1; m_inflight = 0; m_data = '0; m_exc = '0; m_err = 2'b01;
            end else if (uv[iu]) begin
                m_have = 1; m_inflight = 0; m_data = ures[iu]; m_exc = uexc[iu]; m_err = 2'b00;
            end else begin
                m_have = 0; m_inflight = 1;
            end
        end else if (m_inflight) begin
            if (uv[m_unit]) begin
                m_have = 1; m_inflight = 0; m_data = ures[m_unit]; m_exc = uexc[m_unit]; m_err = 2'b00;
            end else if (m_waited == MC - 1) begin
                m_have = 1; m_inflight = 0; m_data = '0; m_exc = '0; m_err = 2'b10;
            end
            m_waited++;
        end else if (m_have && bus.res_ready_i) begin
            m_have = 0;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 1'b0;
        bus.issue_valid_i = 1'b0; bus.issue_unit_i = '0; bus.issue_is_cap_i = 1'b0;
        bus.kill_i = 1'b0; bus.res_ready_i = 1'b0;
        uv = '0;
        for (int u = 0; u < NU; u++) begin
            ures[u] = '0;
            uexc[u] = '0;
        end
    endtask

    task automatic randomize_inputs();
        bus.issue_valid_i  = 1'($urandom_range(0, 1));
        bus.issue_unit_i   = 3'($urandom_range(0, 7));
        bus.issue_is_cap_i = 1'($urandom_range(0, 1));
        bus.kill_i         = ($urandom_range(0, 19) == 0);
        bus.res_ready_i    = ($urandom_range(0, 3) != 0);
        uv = NU'($urandom & $urandom);
        for (int u = 0; u < NU; u++) begin
            ures[u] = RW'({$urandom, $urandom, $urandom});
            uexc[u] = EW'($urandom);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        m_inflight = 0; m_have = 0; m_fresh = 1; m_unit = 0; m_waited = 0;
        m_data = '0; m_exc = '0; m_cap = 1'b0; m_err = 2'b00; last_kill = '0;
        @(posedge clk);
        @(negedge clk);

        // Reset held two cycles under random inputs.
        for (int i = 0; i < 2; i++) begin
            randomize_inputs();
            rst = 1'b1;
            cycle();
        end
        idle_inputs();
        cycle();
        chk("ready_after_reset", 128'(bus.issue_ready_o), 128'(1));

        // Four back-to-back single-cycle ALU ops.
        starts_seen = 0;
        for (int k = 0; k < 4; k++) begin
            bus.issue_valid_i = 1'b1; bus.issue_unit_i = '0; bus.res_ready_i = 1'b1;
            uv = NU'(1); ures[0] = RW'(32'h1234 + k);
            cycle();
            chk("alu_valid", 128'(bus.res_valid_o), 128'(1));
            chk("alu_data", 128'(bus.res_data_o), 128'(32'h1234 + k));
        end
        chk("alu_starts", 128'(starts_seen), 128'(4));
        idle_inputs(); bus.res_ready_i = 1'b1;
        cycle();

        // Multi-cycle unit 1 answering in its fifth wait cycle.
        idle_inputs(); busy_seen = 0;
        bus.issue_valid_i = 1'b1; bus.issue_unit_i = 3'd1; bus.issue_is_cap_i = 1'b1;
        cycle();
        bus.issue_valid_i = 1'b0; bus.issue_is_cap_i = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        uv = NU'(2); ures[1] = RW'(16'hABCD); uexc[1] = 5'h04;
        cycle();
        chk("mc_busy_cycles", 128'(busy_seen), 128'(5));
        chk("mc_data", 128'(bus.res_data_o), 128'(16'hABCD));
        chk("mc_exc", 128'(bus.res_exc_o), 128'(5'h04));
        chk("mc_is_cap", 128'(bus.res_is_cap_o), 128'(1));

        // Back-pressure with a new ALU op pending.
        idle_inputs();
        bus.issue_valid_i = 1'b1; bus.issue_unit_i = '0; uv = NU'(1); ures[0] = RW'(8'h55);
        for (int i = 0; i < 3; i++) cycle();
        chk("bp_hold_data", 128'(bus.res_data_o), 128'(16'hABCD));
        bus.res_ready_i = 1'b1;
        cycle();
        chk("bp_new_data", 128'(bus.res_data_o), 128'(8'h55));
        idle_inputs(); bus.res_ready_i = 1'b1;
        cycle();

        // Watchdog on unit 2.
        idle_inputs(); kills_seen = 0;
        bus.issue_valid_i = 1'b1; bus.issue_unit_i = 3'd2;
        cycle();
        bus.issue_valid_i = 1'b0;
        for (int i = 0; i < MC; i++) cycle();
        chk("to_valid", 128'(bus.res_valid_o), 128'(1));
        chk("to_err", 128'(bus.res_err_o), 128'(2'b10));
        chk("to_kill_count", 128'(kills_seen), 128'(1));
        chk("to_kill_vec", 128'(last_kill), 128'(6'b000100));
        bus.res_ready_i = 1'b1;
        cycle();

        // Kill in the second wait cycle, then kill racing a unit result.
        idle_inputs();
        bus.issue_valid_i = 1'b1; bus.issue_unit_i = 3'd3;
        cycle();
        bus.issue_valid_i = 1'b0;
        cycle();
        bus.kill_i = 1'b1;
        cycle();
        chk("kill_vec", 128'(last_kill), 128'(6'b001000));
        chk("kill_busy", 128'(bus.busy_o), 128'(0));
        bus.kill_i = 1'b0; bus.issue_valid_i = 1'b1;
        cycle();
        bus.issue_valid_i = 1'b0; bus.kill_i = 1'b1; uv = NU'(8);
        cycle();
        chk("kill_race_valid", 128'(bus.res_valid_o), 128'(0));

        // Illegal unit index.
        idle_inputs();
        bus.issue_valid_i = 1'b1; bus.issue_unit_i = 3'd7;
        cycle();
        chk("ill_err", 128'(bus.res_err_o), 128'(2'b01));
        chk("ill_data", 128'(bus.res_data_o), 128'(0));
        idle_inputs(); bus.res_ready_i = 1'b1;
        cycle();

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            randomize_inputs();
            rst = ($urandom_range(0, 99) == 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
